// File: rtl/bsg_xor_checksum.sv
// Streaming XOR-fold checksum: folds accepted words until last_i or the length cap,
// then holds checksum/count/overflow on a valid/yumi output. Option: BSG_XOR_CHECKSUM_ROTATE_EN.
module bsg_xor_checksum #(
  parameter int width_p     = 16,
  parameter int max_words_p = 64
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               v_i,
  input  logic [width_p-1:0]                 data_i,
  input  logic                               last_i,
  output logic                               ready_o,
  output logic                               v_o,
  output logic [width_p-1:0]                 data_o,
  output logic [$clog2(max_words_p+1)-1:0]   count_o,
  output logic                               overflow_o,
  input  logic                               yumi_i
);

  localparam int cnt_w_lp = $clog2(max_words_p+1);
  localparam logic [cnt_w_lp-1:0] cap_m1_lp = cnt_w_lp'(max_words_p - 1);

  typedef enum logic {eAccum, eHold} state_e;

  state_e                state_q, state_d;
  logic [width_p-1:0]    acc_q, acc_d;
  logic [width_p-1:0]    fold;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  accept;
  logic                  at_cap;
  logic                  close;

`ifdef BSG_XOR_CHECKSUM_ROTATE_EN
  // rotate-left-by-1 makes the checksum depend on word order
  assign fold = {acc_q[width_p-2:0], acc_q[width_p-1]};
`else
  assign fold = acc_q;
`endif

  assign accept = v_i & (state_q == eAccum);
  assign at_cap = (cnt_q == cap_m1_lp);
  assign close  = accept & (last_i | at_cap);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= eAccum;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      eAccum:  if (close)  state_d = eHold;
      eHold:   if (yumi_i) state_d = eAccum;
      default: state_d = eAccum;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      acc_d = fold ^ data_i;
      cnt_d = cnt_q + cnt_w_lp'(1);
      if (close) ovf_d = at_cap & ~last_i;
    end else if ((state_q == eHold) && yumi_i) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Result fields are gated so they read zero whenever no result is offered.
  always_comb begin
    ready_o    = (state_q == eAccum) & ~reset_i;
    v_o        = (state_q == eHold);
    data_o     = v_o ? acc_q : '0;
    count_o    = v_o ? cnt_q : '0;
    overflow_o = v_o & ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == eAccum))
      assert (!yumi_i) else $error("bsg_xor_checksum: yumi_i with no result held");
  end

endmodule

// File: tb/tb_bsg_xor_checksum.sv
// Directed self-checking bench for bsg_xor_checksum (default 16-bit, 64-word cap).
module tb_bsg_xor_checksum;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        last_i;
  logic        ready_o;
  logic        v_o;
  logic [15:0] data_o;
  logic [6:0]  count_o;
  logic        overflow_o;
  logic        yumi_i;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_acc;

  bsg_xor_checksum #(.width_p(16), .max_words_p(64)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .count_o(count_o),
    .overflow_o(overflow_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] ref_fold(input logic [15:0] x);
`ifdef BSG_XOR_CHECKSUM_ROTATE_EN
    return {x[14:0], x[15]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic take();
    yumi_i = 1'b1;
    cyc();
    yumi_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; last_i = 1'b0; yumi_i = 1'b0;
    #2;
    chk("rst_ready", ready_o, 0);
    chk("rst_v", v_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", overflow_o, 0);
    cyc(); cyc();
    #2 reset_i = 1'b0;
    #1 chk("post_rst_ready", ready_o, 1);
    cyc();

    // three back-to-back words
    v_i = 1'b1; data_i = 16'h00FF; last_i = 1'b0; cyc();
    data_i = 16'h0F0F; cyc();
    chk("t1_no_early_v", v_o, 0);
    data_i = 16'hFFFF; last_i = 1'b1; cyc();
    v_i = 1'b0; last_i = 1'b0;
    chk("t1_v", v_o, 1);
`ifdef BSG_XOR_CHECKSUM_ROTATE_EN
    chk("t1_data", data_o, 16'hE21D);
`else
    chk("t1_data", data_o, 16'hF00F);
`endif
    chk("t1_count", count_o, 3);
    chk("t1_ovf", overflow_o, 0);
    chk("t1_ready", ready_o, 0);
    take();
    chk("t1_v_clear", v_o, 0);
    chk("t1_ready_back", ready_o, 1);

    // single word, immediate yumi
    v_i = 1'b1; data_i = 16'h1234; last_i = 1'b1; cyc();
    v_i = 1'b0; last_i = 1'b0;
    chk("t2_data", data_o, 16'h1234);
    chk("t2_count", count_o, 1);
    chk("t2_ready_low", ready_o, 0);
    take();
    chk("t2_ready_high", ready_o, 1);

    // cap: 64 words of 0x0001, 65th presented stays pending
    exp_acc = '0;
    v_i = 1'b1; last_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      data_i = 16'h0001;
      exp_acc = ref_fold(exp_acc) ^ 16'h0001;
      cyc();
    end
    data_i = 16'h0005;
    chk("t3_v", v_o, 1);
    chk("t3_count", count_o, 64);
    chk("t3_ovf", overflow_o, 1);
    chk("t3_data", data_o, exp_acc);
`ifndef BSG_XOR_CHECKSUM_ROTATE_EN
    chk("t3_data_even", data_o, 16'h0000);
`endif
    cyc();
    chk("t3_65th_blocked", count_o, 64);
    chk("t3_ready", ready_o, 0);
    take();
    chk("t3_ready_back", ready_o, 1);
    last_i = 1'b1; cyc();
    v_i = 1'b0; last_i = 1'b0;
    chk("t3_next_data", data_o, 16'h0005);
    chk("t3_next_count", count_o, 1);
    chk("t3_next_ovf", overflow_o, 0);
    take();

    // hold stall with v_i asserted
    v_i = 1'b1; data_i = 16'h00A5; last_i = 1'b1; cyc();
    data_i = 16'h5A5A;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_hold_v", v_o, 1);
      chk("t4_hold_data", data_o, 16'h00A5);
      chk("t4_hold_count", count_o, 1);
    end
    take();
    chk("t4_ready_after_yumi", ready_o, 1);
    cyc();
    v_i = 1'b0; last_i = 1'b0;
    chk("t4_new_v", v_o, 1);
    chk("t4_new_data", data_o, 16'h5A5A);
    chk("t4_new_count", count_o, 1);
    take();

    // asynchronous reset mid-frame
    v_i = 1'b1; data_i = 16'h1111; last_i = 1'b0; cyc();
    data_i = 16'h2222; cyc();
    v_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk("t5_rst_ready", ready_o, 0);
    chk("t5_rst_v", v_o, 0);
    chk("t5_rst_data", data_o, 0);
    chk("t5_rst_count", count_o, 0);
    cyc();
    #3 reset_i = 1'b0;
    @(negedge clk_i);
    chk("t5_ready_after", ready_o, 1);
    #4;
    v_i = 1'b1; data_i = 16'hAAAA; last_i = 1'b1; cyc();
    v_i = 1'b0; last_i = 1'b0;
    chk("t5_data", data_o, 16'hAAAA);
    chk("t5_count", count_o, 1);
    take();

    // capping word also carries last_i
    exp_acc = '0;
    v_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      data_i = 16'h0003;
      last_i = (i == 63);
      exp_acc = ref_fold(exp_acc) ^ 16'h0003;
      cyc();
    end
    v_i = 1'b0; last_i = 1'b0;
    chk("t6_v", v_o, 1);
    chk("t6_count", count_o, 64);
    chk("t6_ovf", overflow_o, 0);
    chk("t6_data", data_o, exp_acc);
    take();
    chk("t6_cleared", v_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
